// File: rtl/mem_port_arbiter.sv
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              stall_if,
  output logic              stall_dm,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;

  localparam logic [2:0] LAT_INIT   = 3'(MEM_LAT);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state, state_nxt;
  owner_t     owner;
  logic [2:0] lat_cnt;
  logic [3:0] starve_cnt;
  logic       drop;
  logic       store_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (if_gnt || dm_gnt) state_nxt = BUSY;
      BUSY: if (lat_cnt == 3'd1)  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    if_gnt    = '0;
    dm_gnt    = '0;
    mem_en    = '0;
    mem_we    = '0;
    mem_addr  = dm_addr;
    mem_wdata = dm_wdata;
    stall_if  = '0;
    stall_dm  = '0;
    if (rst_n) begin
      if (state == IDLE) begin
        if_gnt = if_req && (!dm_req || (starve_cnt == STARVE_LIM));
        dm_gnt = dm_req && !if_gnt;
      end
      mem_en   = if_gnt || dm_gnt;
      mem_we   = dm_gnt && dm_we;
      if (if_gnt) mem_addr = if_addr;
      stall_if = if_req && !if_gnt;
      stall_dm = dm_req && !dm_gnt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner      <= OWN_IF;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      drop       <= '0;
      store_q    <= '0;
      if_rvalid  <= '0;
      dm_rvalid  <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      if_rvalid <= '0;
      dm_rvalid <= '0;
      if (state == IDLE) begin
        if (if_gnt) begin
          owner   <= OWN_IF;
          lat_cnt <= LAT_INIT;
          drop    <= if_flush;
        end else if (dm_gnt) begin
          owner   <= OWN_DM;
          lat_cnt <= LAT_INIT;
          store_q <= dm_we;
          drop    <= '0;
        end
        if (!if_req || if_gnt)
          starve_cnt <= '0;
        else if (dm_gnt && (starve_cnt < STARVE_LIM))
          starve_cnt <= starve_cnt + 4'd1;
      end else begin
        lat_cnt <= lat_cnt - 3'd1;
        if ((owner == OWN_IF) && if_flush) drop <= 1'b1;
        if (lat_cnt == 3'd1) begin
          drop <= '0;
          if (owner == OWN_DM) begin
            dm_rvalid <= 1'b1;
            if (!store_q) dm_rdata <= mem_rdata;
          end else if (!(drop || if_flush)) begin
            // a flush arriving in the completion cycle still cancels the fetch
            if_rvalid <= 1'b1;
            if_rdata  <= mem_rdata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int unsigned AW   = 8;
  localparam int unsigned DW   = 32;
  localparam int unsigned LAT  = 2;
  localparam int unsigned SMAX = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req, if_flush, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, dm_rdata;
  logic          stall_if, stall_dm, mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .stall_if(stall_if), .stall_dm(stall_dm),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] pat(int unsigned a);
    logic [7:0] b;
    b = 8'(a);
    return {16'h1357, b, ~b};
  endfunction

  // memory macro: data valid only in the cycle exactly LAT after issue
  logic [31:0] mem [256];
  logic [7:0]  rd_addr;
  int unsigned lat_left = 0;
  initial for (int unsigned i = 0; i < 256; i++) mem[i] = pat(i);
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      rd_addr  <= mem_addr;
      lat_left <= LAT;
    end else if (lat_left != 0) begin
      lat_left <= lat_left - 1;
    end
  end
  assign mem_rdata = (lat_left == 1) ? mem[rd_addr] : 32'hBAD0_BAD0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  exp_t        if_q[$];
  exp_t        dm_q[$];
  logic [31:0] last_if = '0;
  logic [31:0] last_dm = '0;

  task automatic push_if(logic [31:0] d);
    exp_t e;
    e.due = cyc + LAT + 1;
    e.data = d;
    if_q.push_back(e);
    last_if = d;
  endtask

  task automatic push_dm(logic [31:0] d, logic store);
    exp_t e;
    e.due = cyc + LAT + 1;
    e.data = store ? last_dm : d;
    dm_q.push_back(e);
    if (!store) last_dm = d;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (if_q.size() > 0 && if_q[0].due == cyc) begin
      e = if_q.pop_front();
      check("if_rvalid", if_rvalid, 1);
      check("if_rdata", if_rdata, e.data);
    end else if (if_rvalid !== 1'b0) begin
      check("if_rvalid_spurious", if_rvalid, 0);
    end
    if (dm_q.size() > 0 && dm_q[0].due == cyc) begin
      e = dm_q.pop_front();
      check("dm_rvalid", dm_rvalid, 1);
      check("dm_rdata", dm_rdata, e.data);
    end else if (dm_rvalid !== 1'b0) begin
      check("dm_rvalid_spurious", dm_rvalid, 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int unsigned n);
    repeat (n) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic exp_if;
    rst_n = 1'b0; if_req = 1'b1; dm_req = 1'b1; if_flush = 1'b0; dm_we = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;

    // reset with both requests asserted: everything forced low
    step(); @(negedge clk);
    check("rst_if_gnt", if_gnt, 0);
    check("rst_dm_gnt", dm_gnt, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_stall_if", stall_if, 0);
    check("rst_stall_dm", stall_dm, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_dm_rdata", dm_rdata, 0);
    step(); rst_n = 1'b1; if_req = 1'b0; dm_req = 1'b0;
    @(negedge clk);
    check("post_rst_stall_if", stall_if, 0);
    idle(1);

    // single fetch
    step(); if_req = 1'b1; if_addr = 8'h04;
    @(negedge clk);
    check("fetch_if_gnt", if_gnt, 1);
    check("fetch_dm_gnt", dm_gnt, 0);
    check("fetch_mem_en", mem_en, 1);
    check("fetch_mem_we", mem_we, 0);
    check("fetch_mem_addr", mem_addr, 32'h04);
    check("fetch_stall_if", stall_if, 0);
    push_if(pat(8'h04));
    step(); if_req = 1'b0;
    idle(LAT);

    // contention: DM wins, IF stalls through the access
    step(); if_req = 1'b1; if_addr = 8'h08; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 8'h10;
    @(negedge clk);
    check("cont_dm_gnt", dm_gnt, 1);
    check("cont_if_gnt", if_gnt, 0);
    check("cont_stall_if", stall_if, 1);
    check("cont_stall_dm", stall_dm, 0);
    check("cont_mem_addr", mem_addr, 32'h10);
    push_dm(pat(8'h10), 1'b0);
    for (int unsigned k = 1; k <= LAT; k++) begin
      step(); dm_req = 1'b0;
      @(negedge clk);
      check("cont_busy_if_gnt", if_gnt, 0);
      check("cont_busy_stall_if", stall_if, 1);
      check("cont_busy_mem_en", mem_en, 0);
    end
    step();
    @(negedge clk);
    check("cont_late_if_gnt", if_gnt, 1);
    check("cont_late_mem_addr", mem_addr, 32'h08);
    check("cont_late_stall_if", stall_if, 0);
    push_if(pat(8'h08));
    step(); if_req = 1'b0;
    idle(LAT);

    // starvation: DM, DM, IF forced, then DM again after the counter clears
    for (int unsigned k = 0; k < 4; k++) begin
      step();
      if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0;
      if_addr = (k < 3) ? 8'h0C : 8'h0E;
      dm_addr = 8'(8'h30 + k);
      exp_if = (k == 2);
      @(negedge clk);
      check("starve_if_gnt", if_gnt, exp_if);
      check("starve_dm_gnt", dm_gnt, !exp_if);
      check("starve_stall_if", stall_if, !exp_if);
      check("starve_stall_dm", stall_dm, exp_if);
      if (exp_if) push_if(pat(8'h0C));
      else        push_dm(pat(8'h30 + k), 1'b0);
      for (int unsigned j = 0; j < LAT; j++) begin
        step();
        @(negedge clk);
        check("starve_busy_gnt", {if_gnt, dm_gnt}, 0);
      end
    end
    step(); if_req = 1'b0; dm_req = 1'b0;
    idle(LAT);

    // store, then load it back
    step(); dm_req = 1'b1; dm_we = 1'b1; dm_addr = 8'h20; dm_wdata = 32'hDEADBEEF;
    @(negedge clk);
    check("st_dm_gnt", dm_gnt, 1);
    check("st_mem_we", mem_we, 1);
    check("st_mem_addr", mem_addr, 32'h20);
    check("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
    push_dm('0, 1'b1);
    step(); dm_req = 1'b0; dm_we = 1'b0;
    idle(LAT);
    step(); dm_req = 1'b1; dm_addr = 8'h20;
    @(negedge clk);
    check("ld_dm_gnt", dm_gnt, 1);
    check("ld_mem_we", mem_we, 0);
    push_dm(32'hDEADBEEF, 1'b0);
    step(); dm_req = 1'b0;
    idle(LAT);

    // flush during BUSY
    step(); if_req = 1'b1; if_addr = 8'h40;
    @(negedge clk);
    check("fl_if_gnt", if_gnt, 1);
    step(); if_req = 1'b0; if_flush = 1'b1;
    for (int unsigned k = 2; k <= LAT; k++) begin
      step(); if_flush = 1'b0;
    end
    step(); if_flush = 1'b0; if_req = 1'b1; if_addr = 8'h44;
    @(negedge clk);
    check("fl_rdata_hold", if_rdata, last_if);
    check("fl_next_if_gnt", if_gnt, 1);
    push_if(pat(8'h44));
    step(); if_req = 1'b0;
    idle(LAT);

    // flush in the grant cycle
    step(); if_req = 1'b1; if_flush = 1'b1; if_addr = 8'h48;
    @(negedge clk);
    check("flg_if_gnt", if_gnt, 1);
    step(); if_req = 1'b0; if_flush = 1'b0;
    idle(LAT);
    @(negedge clk);
    check("flg_rdata_hold", if_rdata, last_if);

    // reset in the middle of a load
    step(); dm_req = 1'b1; dm_we = 1'b0; dm_addr = 8'h50;
    @(negedge clk);
    check("rma_dm_gnt", dm_gnt, 1);
    step(); dm_req = 1'b0; if_req = 1'b1; rst_n = 1'b0;
    @(negedge clk);
    check("rma_if_gnt", if_gnt, 0);
    check("rma_mem_en", mem_en, 0);
    check("rma_stall_if", stall_if, 0);
    step();
    @(negedge clk);
    check("rma_dm_rdata", dm_rdata, 0);
    check("rma_if_rdata", if_rdata, 0);
    last_if = '0; last_dm = '0;
    step(); rst_n = 1'b1; if_req = 1'b0; dm_req = 1'b1; dm_addr = 8'h50;
    @(negedge clk);
    check("rma_regrant", dm_gnt, 1);
    push_dm(pat(8'h50), 1'b0);
    step(); dm_req = 1'b0;
    idle(LAT + 1);
    @(negedge clk);
    check("queues_drained", if_q.size() + dm_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer for the single-port unified memory shared by the pipeline's fetch stage (IF) and memory stage (DM). It accepts one request per cycle from each stage, grants one, drives the memory for a fixed access latency, returns read data with a valid pulse, and raises per-stage stall signals so the pipeline freezes while its stage waits. It sits between the pipeline core and the memory macro inside the chip top.

## Interface
- ADDR_W, 8: memory word-address width
- DATA_W, 32: data width
- MEM_LAT, 1: cycles from issue to mem_rdata valid; legal 1..4
- STARVE_MAX, 4: consecutive IF losses before IF is forced to win; legal 1..15

- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- if_req  in  1  fetch request; held until granted
- if_addr  in  ADDR_W  fetch address
- if_flush  in  1  cancel the in-flight fetch (branch redirect)
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  one-cycle pulse, if_rdata valid
- if_rdata  out  DATA_W  fetched word
- dm_req  in  1  data request; held until granted
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_gnt  out  1  data request accepted this cycle
- dm_rvalid  out  1  one-cycle completion pulse (loads and stores)
- dm_rdata  out  DATA_W  load data
- stall_if, stall_dm  out  1  = req & ~gnt for each port
- mem_en, mem_we  out  1  memory enable / write enable
- mem_addr  out  ADDR_W; mem_wdata  out  DATA_W
- mem_rdata  in  DATA_W  valid MEM_LAT cycles after issue

## Operation
- States: IDLE, BUSY. One access outstanding at a time; memory is non-pipelined.
- IDLE: grant at most one requester combinationally. Default DM wins (older instruction). IF wins if dm_req=0, or starve_cnt == STARVE_MAX.
- Grant cycle: gnt=1, mem_en=1, mem_we=dm_we (DM) or 0 (IF), mem_addr/mem_wdata from granted port; record owner, load lat_cnt=MEM_LAT, go BUSY.
- BUSY: gnt=0, mem_en=0, all requests stall. lat_cnt decrements each cycle; in the cycle lat_cnt==1, capture mem_rdata into owner's rdata register (loads/fetches only), go IDLE, set owner's rvalid for the next cycle.
- Stores: dm_rvalid pulses at completion; dm_rdata keeps its previous value.
- starve_cnt (4 bits): +1 (saturating at STARVE_MAX) on each grant to DM while if_req=1; cleared on IF grant or any IDLE cycle with if_req=0.
- Flush: if_flush=1 during any BUSY cycle with owner IF, or in the same cycle as the IF grant, sets drop flag; at completion if_rdata is not updated and if_rvalid is suppressed. if_flush has no effect otherwise.
- Reset (rst_n=0 at a clock edge): state IDLE, starve_cnt=0, drop=0, rvalids=0, rdata regs=0. In-flight access abandoned, no rvalid. While rst_n=0 is sampled, all gnt, mem_en, mem_we and stall outputs are forced 0.

## Timing
- Grant in cycle T → rdata captured end of T+MEM_LAT → rvalid high in T+MEM_LAT+1 only.
- State is IDLE in T+MEM_LAT+1; a new grant may occur in that same cycle. Peak throughput one access per MEM_LAT+1 cycles.
- if_rvalid and dm_rvalid never high together; gnt signals mutually exclusive.
- Simultaneous if_req and dm_req with starve_cnt<STARVE_MAX: DM granted, stall_if=1.
- Outputs after reset: if_gnt=dm_gnt=0, if_rvalid=dm_rvalid=0, if_rdata=dm_rdata=0, mem_en=mem_we=0; stall_* = req once rst_n=1.

## Test plan
- Single fetch, MEM_LAT=1: if_req, if_addr=0x04, mem returns 0x00000013 → if_gnt cycle T, mem_en/mem_addr=0x04 in T, if_rvalid and if_rdata=0x00000013 in T+2.
- Contention: if_req and dm_req (load 0x10) both high in T → dm_gnt in T, stall_if=1 through T+1, if_gnt in T+2.
- Starvation, STARVE_MAX=2: if_req held, dm_req re-asserted every IDLE cycle → DM granted twice, third arbitration grants IF despite dm_req=1; starve_cnt returns 0.
- Store, MEM_LAT=3: dm_we=1, dm_addr=0x20, dm_wdata=0xDEADBEEF → mem_we=1 in T, dm_rvalid in T+4, dm_rdata unchanged.
- Flush: fetch granted in T (MEM_LAT=2), if_flush=1 in T+1 → no if_rvalid in T+3, if_rdata unchanged; next IF grant possible in T+3.
- Reset mid-access: rst_n=0 in T+1 of a MEM_LAT=3 load → no dm_rvalid ever for it, all outputs 0, state IDLE; request after release granted normally.
